// File: rtl/upload_arbiter.sv
// upload_arbiter: round-robin arbiter that merges NUM_SRC byte streams into
// one USB upload path. A grant is held for a whole packet (until src_last or
// a stall timeout). Optional feature macro UPLOAD_ARB_SRC_TAG_EN prefixes
// each packet with a tag byte 8'hA0 | grant_id.
`timescale 1ns/1ps

module upload_arbiter #(
   parameter int NUM_SRC     = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_SRC-1:0]     src_valid,
   input  logic [8*NUM_SRC-1:0]   src_data,
   input  logic [NUM_SRC-1:0]     src_last,
   output logic [NUM_SRC-1:0]     src_ready,
   output logic [7:0]             up_data,
   output logic                   up_valid,
   input  logic                   up_ready,
   output logic [2:0]             grant_id,
   output logic                   busy,
   output logic                   timeout_err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      TAG  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT_CYC - 1);

   state_t      state;
   state_t      state_next;
   logic [2:0]  rr_ptr;
   logic [15:0] stall_cnt;

   logic        sel_valid;
   logic        sel_last;
   logic [7:0]  sel_data;
   logic        req_found;
   logic [2:0]  req_idx;
   logic        out_free;
   logic        beat;
   logic        last_beat;
   logic        stalling;
   logic        timeout_hit;
   logic        tag_load;
   logic [2:0]  next_ptr;

   assign out_free    = !up_valid || up_ready;
   assign beat        = (state == XFER) && sel_valid && out_free;
   assign last_beat   = beat && sel_last;
   assign stalling    = (state == XFER) && !sel_valid;
   assign timeout_hit = stalling && (stall_cnt == STALL_LIMIT);
   assign next_ptr    = (grant_id == 3'(NUM_SRC - 1)) ? 3'd0 : grant_id + 3'd1;
   assign busy        = (state != IDLE);

`ifdef UPLOAD_ARB_SRC_TAG_EN
   assign tag_load = (state == TAG) && out_free;
`else
   assign tag_load = 1'b0;
`endif

   // Pick out the granted source's valid/last/byte without a variable index
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = 8'h00;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_id == 3'(i)) begin
            sel_valid = src_valid[i];
            sel_last  = src_last[i];
            sel_data  = src_data[8*i +: 8];
         end
      end
   end

   // Search requesters upward from rr_ptr with wrap; first hit wins
   always_comb begin
      req_found = 1'b0;
      req_idx   = rr_ptr;
      for (int k = 0; k < NUM_SRC; k++) begin
         for (int j = 0; j < NUM_SRC; j++) begin
            if (!req_found && src_valid[j] && (j == (int'(rr_ptr) + k) % NUM_SRC)) begin
               req_found = 1'b1;
               req_idx   = 3'(j);
            end
         end
      end
   end

   // Only the granted source may see ready, and only while the output can take a byte
   always_comb begin
      src_ready = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if ((grant_id == 3'(i)) && (state == XFER) && out_free) begin
            src_ready[i] = 1'b1;
         end
      end
   end

   // Next-state logic: grant from IDLE, optional tag, release on last or timeout
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_found) begin
`ifdef UPLOAD_ARB_SRC_TAG_EN
               state_next = TAG;
`else
               state_next = XFER;
`endif
            end
         end
         TAG: begin
            if (out_free) begin
               state_next = XFER;
            end
         end
         XFER: begin
            if (last_beat || timeout_hit) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant, round-robin pointer, stall counter and timeout pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_id    <= 3'd0;
         rr_ptr      <= 3'd0;
         stall_cnt   <= 16'd0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= timeout_hit;
         if ((state == IDLE) && req_found) begin
            grant_id <= req_idx;
         end
         if (last_beat || timeout_hit) begin
            rr_ptr <= next_ptr;
         end
         if ((state != XFER) || beat) begin
            stall_cnt <= 16'd0;
         end else if (stalling) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
      end
   end

   // Output register: data beat, tag byte, or drain on downstream accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_data  <= 8'h00;
         up_valid <= 1'b0;
      end else if (beat) begin
         up_data  <= sel_data;
         up_valid <= 1'b1;
      end else if (tag_load) begin
         up_data  <= 8'hA0 | {5'd0, grant_id};
         up_valid <= 1'b1;
      end else if (up_ready) begin
         up_valid <= 1'b0;
      end
   end

endmodule

// File: doc/upload_arbiter.md
UPLOAD_ARBITER -- requirements
Module: upload_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of upload requesters, legal range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, stall cycles allowed mid-packet before forced release, legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port src_valid  input  NUM_SRC  per-source byte valid.
REQ-006 SHALL have port src_data  input  8*NUM_SRC  per-source byte; source i uses bits [8*i+7:8*i].
REQ-007 SHALL have port src_last  input  NUM_SRC  per-source end-of-packet marker, qualified by src_valid.
REQ-008 SHALL have port src_ready  output  NUM_SRC  per-source accept; one bit high at most.
REQ-009 SHALL have port up_data  output  8  byte to USB upload path.
REQ-010 SHALL have port up_valid  output  1  up_data valid, held until accepted.
REQ-011 SHALL have port up_ready  input  1  downstream accept.
REQ-012 SHALL have port grant_id  output  3  index of the source currently granted.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-014 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.

Function
REQ-015 SHALL implement states IDLE, TAG and XFER; TAG is reachable only when UPLOAD_ARB_SRC_TAG_EN is defined.
REQ-016 In IDLE with any src_valid high, the arbiter SHALL grant the first requesting index found by searching upward from rr_ptr with wrap, load grant_id, and move to TAG (macro defined) or XFER (otherwise) on the next edge.
REQ-017 A source-to-output beat SHALL occur in a cycle when state=XFER, src_valid[grant_id]=1, and (up_valid=0 or up_ready=1); src_ready[grant_id] SHALL be combinationally high exactly when state=XFER and (up_valid=0 or up_ready=1).
REQ-018 The output register SHALL load the beat byte and set up_valid on the edge ending a beat cycle, giving 1-cycle latency; up_valid SHALL clear on up_ready when no new byte is loaded.
REQ-019 up_data and up_valid SHALL NOT change while up_valid=1 and up_ready=0.
REQ-020 The grant SHALL be locked for the whole packet; other src_valid bits SHALL be ignored until release.
REQ-021 A beat carrying src_last=1 SHALL return the state to IDLE and set rr_ptr to (grant_id+1) mod NUM_SRC.
REQ-022 A stall counter SHALL count consecutive XFER cycles with src_valid[grant_id]=0, clear on every beat, and on reaching TIMEOUT_CYC SHALL return the state to IDLE, pulse timeout_err, and advance rr_ptr as in REQ-021.
REQ-023 A byte already in the output register at release SHALL still be delivered; IDLE SHALL NOT stall on it.
REQ-024 A single-byte packet, where the first beat carries src_last=1, SHALL be legal and SHALL release after that beat.

Reset
REQ-025 While rst is high, the block SHALL hold state=IDLE, rr_ptr=0, grant_id=0, up_valid=0, up_data=0x00, busy=0, timeout_err=0, stall counter=0, and src_ready all zero.
REQ-026 Reset asserted mid-packet SHALL discard the packet and any pending output byte without emitting further bytes.

Configuration
REQ-027 When macro UPLOAD_ARB_SRC_TAG_EN is defined, TAG SHALL load up_data=8'hA0|grant_id into the output register when it is free (up_valid=0 or up_ready=1), keep src_ready low, and then enter XFER, so each packet is preceded by one tag byte.
REQ-028 When UPLOAD_ARB_SRC_TAG_EN is undefined, no tag byte SHALL be emitted and IDLE SHALL go directly to XFER.

Verification
REQ-029 Source 0 sends 3 bytes 0x11,0x22,0x33 (last on 0x33) with up_ready=1 -> up_data 0x11,0x22,0x33 on consecutive cycles, each 1 cycle after its beat; rr_ptr=1 at the end.
REQ-030 Sources 0 and 2 both request continuously, one 2-byte packet each, with rr_ptr=0 -> all of source 0's packet precedes all of source 2's; no interleaving.
REQ-031 up_ready held low for 5 cycles with up_valid=1 and data 0x5A -> up_data stays 0x5A and src_ready stays 0 for all 5 cycles.
REQ-032 With TIMEOUT_CYC=8, source 1 sends 1 byte without last and then drops valid -> timeout_err pulses exactly 8 cycles later and the state returns to IDLE.
REQ-033 With the macro defined, source 3 sends a 1-byte packet 0x7E -> output is 0xA3 then 0x7E.
REQ-034 rst is pulsed during the second byte of a 4-byte packet -> up_valid=0 and busy=0 immediately, and no further bytes of that packet appear.
